// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame tick generator and one-at-a-time object update scheduler
// Optional watchdog: define SEQ_TIMEOUT_EN to enable per-object timeout and TIMEOUT_ERR.
module frame_sequencer #(
  parameter int NUM_OBJ        = 2,
  parameter int FRAME_CYCLES   = 833333,
  parameter int UPDATE_EVERY   = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_OBJ-1:0] DONE,
  input  logic [NUM_OBJ-1:0] EN_MASK,
  input  logic               PAUSE,
  output logic [NUM_OBJ-1:0] ACTIVE,
  output logic               FRAME_TICK,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic               TIMEOUT_ERR
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int UW = (UPDATE_EVERY > 1) ? $clog2(UPDATE_EVERY) : 1;
  localparam logic [FW-1:0]      FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [UW-1:0]      UPD_LAST   = UW'(UPDATE_EVERY - 1);
  localparam logic [NUM_OBJ-1:0] ONE        = NUM_OBJ'(1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             r_state;
  logic [FW-1:0]      r_frame_cnt;
  logic [UW-1:0]      r_upd_cnt;
  logic [NUM_OBJ-1:0] r_mask;
  logic [NUM_OBJ-1:0] r_active;
  logic               r_busy;
  logic               r_overrun;

  logic               w_frame_tick;
  logic               w_update_start;
  logic               w_done_hit;
  logic               w_wd_fire;
  logic               w_advance;
  logic [NUM_OBJ-1:0] w_above;
  logic [NUM_OBJ-1:0] w_next;
  logic [NUM_OBJ-1:0] w_first;

  // Frame counter: counts down, tick on zero, reload to FRAME_CYCLES-1
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_cnt <= FRAME_LAST;
    end else if (r_frame_cnt == '0) begin
      r_frame_cnt <= FRAME_LAST;
    end else begin
      r_frame_cnt <= r_frame_cnt - 1'b1;
    end
  end

  assign w_frame_tick = (r_frame_cnt == '0);

  // Update counter: frames modulo UPDATE_EVERY, advanced on each frame tick
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_upd_cnt <= '0;
    end else if (w_frame_tick) begin
      if (r_upd_cnt == UPD_LAST) begin
        r_upd_cnt <= '0;
      end else begin
        r_upd_cnt <= r_upd_cnt + 1'b1;
      end
    end
  end

  assign w_update_start = w_frame_tick && (r_upd_cnt == '0);

  // Only the active object's DONE bit matters; others are masked off here.
  assign w_done_hit = |(DONE & r_active);

  // Enabled objects strictly above the active one-hot bit, then isolate the lowest.
  assign w_above = r_mask & ~(r_active | (r_active - ONE));
  assign w_next  = w_above & (~w_above + ONE);
  assign w_first = EN_MASK & (~EN_MASK + ONE);

  assign w_advance = (r_state == S_RUN) && (w_done_hit || w_wd_fire);

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] r_wd_cnt;
  logic          r_timeout_err;

  // Firing on the last count keeps each stalled object active for exactly TIMEOUT_CYCLES cycles.
  assign w_wd_fire = (r_state == S_RUN) && !w_done_hit && (r_wd_cnt == WD_LAST);

  // Watchdog counter: restarts whenever ACTIVE changes, counts while running
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_RUN || w_advance) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_timeout_err <= 1'b0;
    end else if (w_wd_fire) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign TIMEOUT_ERR = r_timeout_err;
`else
  assign w_wd_fire   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  // Sequencer FSM: start on update frames, hand over object by object, flag overruns
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_active  <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A paused start is simply dropped; an empty mask is a legal no-op.
          if (w_update_start && !PAUSE) begin
            r_mask <= EN_MASK;
            if (EN_MASK != '0) begin
              r_state  <= S_RUN;
              r_active <= w_first;
              r_busy   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // The running sequence always completes; a colliding start is only recorded.
          if (w_update_start) begin
            r_overrun <= 1'b1;
          end
          if (w_advance) begin
            if (w_next != '0) begin
              r_active <= w_next;
            end else begin
              r_active <= '0;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign ACTIVE     = r_active;
  assign BUSY       = r_busy;
  assign OVERRUN    = r_overrun;
  assign FRAME_TICK = w_frame_tick;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - randomized bench for frame_sequencer against a queue-based reference model
module tb_frame_sequencer;

  localparam int NUM_OBJ = 3;
  localparam int FC      = 10;
  localparam int UE      = 2;
  localparam int TO      = 8;

  logic               CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic [NUM_OBJ-1:0] DONE = '0;
  logic [NUM_OBJ-1:0] EN_MASK = '0;
  logic               PAUSE = 1'b0;
  logic [NUM_OBJ-1:0] ACTIVE;
  logic               FRAME_TICK;
  logic               BUSY;
  logic               OVERRUN;
  logic               TIMEOUT_ERR;

  frame_sequencer #(
    .NUM_OBJ        (NUM_OBJ),
    .FRAME_CYCLES   (FC),
    .UPDATE_EVERY   (UE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DONE        (DONE),
    .EN_MASK     (EN_MASK),
    .PAUSE       (PAUSE),
    .ACTIVE      (ACTIVE),
    .FRAME_TICK  (FRAME_TICK),
    .BUSY        (BUSY),
    .OVERRUN     (OVERRUN),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles since reset release, queue of objects still to run
  int   m_cyc;
  int   m_pend[$];
  int   m_wd;
  logic m_ovr;
  logic m_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, got, exp, $time, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_pend.delete();
    m_wd  = 0;
    m_ovr = 1'b0;
    m_tmo = 1'b0;
  endtask

  task automatic compare_all();
    logic [NUM_OBJ-1:0] exp_act;
    exp_act = '0;
    if (m_pend.size() != 0) exp_act[m_pend[0]] = 1'b1;
    check("active", ACTIVE, exp_act);
    check("busy", BUSY, m_pend.size() != 0);
    check("frame_tick", FRAME_TICK, (m_cyc % FC) == FC - 1);
    check("overrun", OVERRUN, m_ovr);
    check("timeout_err", TIMEOUT_ERR, m_tmo);
  endtask

  // One clock edge of the reference behaviour, using the inputs present before the edge
  task automatic model_edge();
    bit tick;
    bit start;
    bit was_busy;
    bit d;
    bit to;
    tick     = (m_cyc % FC) == FC - 1;
    start    = tick && (((m_cyc / FC) % UE) == 0);
    was_busy = m_pend.size() != 0;
    if (was_busy) begin
      d  = DONE[m_pend[0]];
      to = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to = !d && (m_wd == TO - 1);
`endif
      if (d || to) begin
        void'(m_pend.pop_front());
        m_wd = 0;
        if (to) m_tmo = 1'b1;
      end else begin
        m_wd++;
      end
    end
    if (start) begin
      if (was_busy) begin
        m_ovr = 1'b1;
      end else if (!PAUSE) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          if (EN_MASK[i]) m_pend.push_back(i);
        end
        m_wd = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) begin
      @(negedge CLK);
      compare_all();
    end
    RESET_N = 1'b1;
  endtask

  initial begin
    int dens[3];
    int den;
    dens[0] = 2;
    dens[1] = 6;
    dens[2] = 40;
    model_reset();
    @(negedge CLK);
    do_reset();
    for (int step = 0; step < 3000; step++) begin
      if ((step % 600) == 599) begin
        do_reset();
      end
      den = dens[(step / 400) % 3];
      for (int b = 0; b < NUM_OBJ; b++) begin
        DONE[b] = ($urandom_range(0, den - 1) == 0);
      end
      EN_MASK = NUM_OBJ'($urandom_range(0, (1 << NUM_OBJ) - 1));
      PAUSE   = ($urandom_range(0, 3) == 0);
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare_all();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
